// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory handshakes.
// Optional ILLEGAL_TRAP_EN macro: unknown opcodes enter a sticky TRAP state instead of acting as NOPs.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       btaken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_en,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       dmem_req,
    output logic       dataMem_wr_en,
    output logic       regFile_wr_en,
    output logic       AluSrcMuxSel,
    output logic [2:0] RFWriteDataSrcMuxSel,
    output logic [2:0] extType,
    output logic [3:0] ALUControl,
    output logic       mem_err,
    output logic       illegal_instr
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_IL = 7'b0000011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_UA = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JI = 7'b1100111;

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_IL, C_I, C_S, C_B, C_U, C_UA, C_J, C_JI, C_NONE
    } op_class_e;

    state_e        r_state;
    state_e        w_state_next;
    op_class_e     w_cls;
    logic [CW-1:0] r_wait_cnt;
    logic          w_waiting;
    logic          w_timeout;
    logic          w_unused_f7;

    assign w_unused_f7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        case (op)
            OP_R:    w_cls = C_R;
            OP_IL:   w_cls = C_IL;
            OP_I:    w_cls = C_I;
            OP_S:    w_cls = C_S;
            OP_B:    w_cls = C_B;
            OP_U:    w_cls = C_U;
            OP_UA:   w_cls = C_UA;
            OP_J:    w_cls = C_J;
            OP_JI:   w_cls = C_JI;
            default: w_cls = C_NONE;
        endcase
    end

    // A wait cycle is a request the addressed memory has not yet satisfied.
    assign w_waiting = ((r_state == S_FETCH) && !imem_ready) ||
                       ((r_state == S_MEM)   && !dmem_ready);
    assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (r_wait_cnt == LAST_WAIT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if ((w_state_next != r_state) || w_timeout) begin
            r_wait_cnt <= '0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_BOOT:   w_state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DECODE: w_state_next = S_EXECUTE;
            S_EXECUTE: begin
                case (w_cls)
                    C_IL, C_S: w_state_next = S_MEM;
                    C_B:       w_state_next = S_FETCH;
                    C_R, C_I, C_U, C_UA, C_J, C_JI: w_state_next = S_WB;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        w_state_next = S_TRAP;
`else
                        w_state_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    w_state_next = (w_cls == C_S) ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_state_next = S_FETCH;
                end
            end
            S_WB:     w_state_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   w_state_next = S_TRAP;
`endif
            default:  w_state_next = S_BOOT;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        imem_req             = 1'b0;
        ir_en                = 1'b0;
        pc_en                = 1'b0;
        pc_src               = 2'b00;
        dmem_req             = 1'b0;
        dataMem_wr_en        = 1'b0;
        regFile_wr_en        = 1'b0;
        AluSrcMuxSel         = 1'b0;
        RFWriteDataSrcMuxSel = 3'b000;
        extType              = 3'b000;
        ALUControl           = 4'b0000;
        mem_err              = 1'b0;
        illegal_instr        = 1'b0;

        // Decode fields are held at zero in BOOT so reset shows an all-zero interface.
        if (r_state != S_BOOT) begin
            case (w_cls)
                C_R: ALUControl = {funct7[5], funct3};
                C_IL: begin
                    AluSrcMuxSel         = 1'b1;
                    RFWriteDataSrcMuxSel = 3'b001;
                end
                C_I: begin
                    AluSrcMuxSel = 1'b1;
                    ALUControl   = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                end
                C_S: begin
                    AluSrcMuxSel = 1'b1;
                    extType      = 3'b001;
                end
                C_B: begin
                    extType    = 3'b010;
                    ALUControl = {1'b0, funct3};
                end
                C_U: begin
                    RFWriteDataSrcMuxSel = 3'b010;
                    extType              = 3'b011;
                end
                C_UA: begin
                    RFWriteDataSrcMuxSel = 3'b011;
                    extType              = 3'b011;
                end
                C_J: begin
                    RFWriteDataSrcMuxSel = 3'b100;
                    extType              = 3'b100;
                end
                C_JI: begin
                    AluSrcMuxSel         = 1'b1;
                    RFWriteDataSrcMuxSel = 3'b100;
                end
                default: ;
            endcase
        end

        unique case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_en    = imem_ready;
                mem_err  = w_timeout;
            end
            S_EXECUTE: begin
                if (w_cls == C_B) begin
                    pc_en  = 1'b1;
                    pc_src = btaken ? 2'b01 : 2'b00;
                end
`ifndef ILLEGAL_TRAP_EN
                if (w_cls == C_NONE) begin
                    pc_en = 1'b1;
                end
`endif
            end
            S_MEM: begin
                dmem_req      = 1'b1;
                dataMem_wr_en = (w_cls == C_S);
                mem_err       = w_timeout;
                pc_en         = dmem_ready && (w_cls == C_S);
            end
            S_WB: begin
                regFile_wr_en = 1'b1;
                pc_en         = 1'b1;
                if (w_cls == C_J) begin
                    pc_src = 2'b01;
                end else if (w_cls == C_JI) begin
                    pc_src = 2'b10;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:  illegal_instr = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
